pulse_period_meter: RTL

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_meter_pkg.sv | 20 ++
 rtl/lock_tracker.sv | 68 ++++++
 rtl/pulse_period_meter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
// Shared types and constants for pulse_period_meter and its lock_tracker.
//   state_e            : measurement FSM state encoding
//   LOCK_COUNT_DEFAULT : default number of equal periods required for lock
//   RUN_W              : width of the lock run-length counter (LOCK_COUNT <= 15)
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

  localparam int unsigned LOCK_COUNT_DEFAULT = 4;
  localparam int unsigned RUN_W              = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    TIMEOUT    = 2'd3
  } state_e;

endpackage : pulse_meter_pkg

// File: rtl/lock_tracker.sv
// -----------------------------------------------------------------------------
// lock_tracker
// Counts consecutive identical periods and flags lock once LOCK_COUNT equal
// periods have been seen in a row. Fed with the meter's next-state period and
// strobe so that its registered state updates on the same edge as the meter's
// period/period_valid registers; locked therefore rises in the same cycle as
// the period_valid that completes the run.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   period       in   N    period being committed this edge
//   period_valid in   1    a period is committed this edge
//   clear        in   1    forget history (no reference period any more)
//   locked       out  1    run length has reached LOCK_COUNT
// -----------------------------------------------------------------------------
module lock_tracker
  import pulse_meter_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] period,
  input  logic         period_valid,
  input  logic         clear,
  output logic         locked
);

  localparam logic [RUN_W-1:0] RunMax = RUN_W'(LOCK_COUNT);

  // run_q == 0 means "no previous period yet"; the first committed period
  // after a clear starts a run of length 1.
  logic [RUN_W-1:0] run_q, run_d;
  logic [N-1:0]     prev_q, prev_d;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    if (clear) begin
      run_d = '0;
    end else if (period_valid) begin
      prev_d = period;
      if (run_q == '0) begin
        run_d = RUN_W'(1);
      end else if (period == prev_q) begin
        run_d = (run_q == RunMax) ? RunMax : run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= '0;
      prev_q <= '0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
    end
  end

  assign locked = (run_q == RunMax);

endmodule : lock_tracker

// File: rtl/pulse_period_meter.sv
// -----------------------------------------------------------------------------
// pulse_period_meter
// Measures the interval, in clk cycles, between successive single-cycle strobes
// on pulse_in. The first pulse after enable (or after a timeout) only starts
// the measurement; each later pulse reports the distance to the previous one.
// If no pulse arrives within 2^N-1 cycles the meter enters TIMEOUT and waits
// for a fresh first pulse. The counter never wraps.
//
// Optional feature: define PULSE_PERIOD_METER_LOCK_EN to compile in lock
// tracking (lock_tracker sub-module). Without it, locked is tied to 0.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   rst          in   asynchronous active-low reset
//   ena          in   measurement enable; low forces IDLE
//   pulse_in     in   strobe train under measurement
//   period       out  N  last measured interval (registered, holds)
//   period_valid out  1  one-cycle strobe, period updated this cycle
//   timeout      out  1  level, no pulse within the maximum interval
//   locked       out  1  level, LOCK_COUNT consecutive identical periods
// -----------------------------------------------------------------------------
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         timeout,
  output logic         locked
);

  if (LOCK_COUNT < 2 || LOCK_COUNT > 15 || N < 2) begin : g_param_check
    $error("pulse_period_meter: N must be >= 2 and LOCK_COUNT in 2..15");
  end

  // Last count value from which a pulse can still be reported (period 2^N-1).
  localparam logic [N-1:0] CountLast = {{(N-1){1'b1}}, 1'b0};

  state_e         state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic [N-1:0]   period_q, period_d;
  logic           valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      valid_q  <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // count holds (pulse distance - 1): it is cleared on the pulse edge and
  // advances once per following cycle, so a pulse T cycles later sees T-1.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    valid_d  = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (pulse_in) begin
            state_d = MEASURE;
            count_d = '0;
          end
        end
        MEASURE: begin
          // A pulse wins over the timeout check at the last count value.
          if (pulse_in) begin
            period_d = count_q + N'(1);
            valid_d  = 1'b1;
            count_d  = '0;
          end else if (count_q == CountLast) begin
            state_d = TIMEOUT;
          end else begin
            count_d = count_q + N'(1);
          end
        end
        TIMEOUT: begin
          // The pulse that ends a timeout is a new first pulse: no report.
          if (pulse_in) begin
            state_d = MEASURE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    period       = period_q;
    period_valid = valid_q;
    timeout      = (state_q == TIMEOUT);
  end

`ifdef PULSE_PERIOD_METER_LOCK_EN
  // History is discarded whenever the meter is not continuously measuring:
  // while idle or waiting, and on entry to IDLE or TIMEOUT. The first report
  // after that restarts the run at 1.
  logic lock_clear;
  assign lock_clear = (state_q != MEASURE) || (state_d != MEASURE);

  lock_tracker #(
    .N          (N),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock_tracker (
    .clk          (clk),
    .rst          (rst),
    .period       (period_d),
    .period_valid (valid_d),
    .clear        (lock_clear),
    .locked       (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule : pulse_period_meter
